// File: rtl/fake_cd_ctrl_if.sv
// fake_cd_ctrl_if: bridge <-> CD mechanism command, status and data strobe signals
interface fake_cd_ctrl_if;
  logic        COMM_SEND;
  logic [95:0] COMMAND;
  logic        STAT_GET;
  logic [7:0]  STATUS;
  logic [7:0]  CD_DATA;
  logic        CD_WR;
  modport master(output COMM_SEND, COMMAND, STAT_GET, input STATUS, CD_DATA, CD_WR);
  modport slave(input COMM_SEND, COMMAND, STAT_GET, output STATUS, CD_DATA, CD_WR);
endinterface

// File: rtl/fake_cd_ctrl.sv
// fake_cd_ctrl: CD-ROM mechanism stand-in running TEST UNIT READY, REQUEST SENSE and READ(6); define FAKE_CD_TOC_EN to add READ TOC (0xDE)
module fake_cd_ctrl #(
  parameter int BYTE_GAP     = 8,
  parameter int SECTOR_BYTES = 2048
) (
  input logic           CLK,
  input logic           RES,
  fake_cd_ctrl_if.slave bus
);
  localparam int GW = $clog2(BYTE_GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STAT} state_t;
  typedef enum logic [1:0] {K_RS, K_RD, K_TOC} kind_t;
  state_t        state_q, state_d;
  kind_t         kind_q, kind_d, nk, k_s;
  logic [20:0]   lba_q, lba_d, lba_s, lba_a;
  logic [8:0]    cnt_q, cnt_d, cnt_s;
  logic [8:0]    sec_q, sec_d, s_s;
  logic [10:0]   off_q, off_d, o_s;
  logic [1:0]    sel_q, sel_d, sel_s;
  logic [GW-1:0] gap_q, gap_d;
  logic          last_q, last_d;
  logic [7:0]    sense_q, sense_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    cd_data_q, cd_data_d;
  logic          cd_wr_q, cd_wr_d;
  logic [7:0]    op, b1, b2, b3, b4, byte_s, toc_b;
  logic          is_rs, is_rd, is_toc, is_tur, has_data, accept, fire, last_byte, wrap;
  logic          unused_cmd;
  assign op = bus.COMMAND[7:0];
  assign b1 = bus.COMMAND[15:8];
  assign b2 = bus.COMMAND[23:16];
  assign b3 = bus.COMMAND[31:24];
  assign b4 = bus.COMMAND[39:32];
  assign unused_cmd = ^{bus.COMMAND[95:40], b1[7:5], sel_s};
  assign is_tur = op == 8'h00;
  assign is_rs = op == 8'h03;
  assign is_rd = op == 8'h08;
`ifdef FAKE_CD_TOC_EN
  logic [31:0] toc_w;
  assign is_toc = op == 8'hDE && b1 <= 8'd2;
  assign toc_w = sel_s == 2'd0 ? 32'h0101_0000 : sel_s == 2'd1 ? 32'h6000_0000 : 32'h0002_0004;
  assign toc_b = toc_w[{~o_s[1:0], 3'b000} +: 8];
`else
  assign is_toc = 1'b0;
  assign toc_b = 8'h00;
`endif
  assign has_data = is_rs || is_rd || is_toc;
  assign nk = is_rs ? K_RS : is_toc ? K_TOC : K_RD;
  assign accept = state_q == S_IDLE && bus.COMM_SEND;
  // on the accept cycle the byte generator works from the incoming command, otherwise from the latched one
  assign k_s = accept ? nk : kind_q;
  assign lba_s = accept ? {b1[4:0], b2, b3} : lba_q;
  assign cnt_s = accept ? {b4 == 8'h00, b4} : cnt_q;
  assign sel_s = accept ? b1[1:0] : sel_q;
  assign s_s = accept ? 9'd0 : sec_q;
  assign o_s = accept ? 11'd0 : off_q;
  assign lba_a = lba_s + 21'(s_s);
  assign byte_s = k_s == K_RD ? lba_a[7:0] ^ o_s[7:0] :
                  k_s == K_RS ? (o_s == 11'd0 ? 8'h70 : o_s == 11'd2 ? sense_q : 8'h00) : toc_b;
  assign wrap = k_s == K_RD && o_s == 11'(SECTOR_BYTES - 1);
  assign last_byte = k_s == K_RD ? wrap && s_s == cnt_s - 9'd1 : k_s == K_RS ? o_s == 11'd17 : o_s == 11'd3;
  assign fire = (accept && has_data && BYTE_GAP == 1) || (state_q == S_DATA && !last_q && gap_q == GW'(1));
  // next-state: command accept, byte pacing, completion and status handshake
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    lba_d = lba_q;
    cnt_d = cnt_q;
    sec_d = sec_q;
    off_d = off_q;
    sel_d = sel_q;
    gap_d = gap_q;
    last_d = last_q;
    sense_d = sense_q;
    status_d = status_q;
    cd_data_d = cd_data_q;
    cd_wr_d = 1'b0;
    if (accept) begin
      kind_d = nk;
      lba_d = {b1[4:0], b2, b3};
      cnt_d = {b4 == 8'h00, b4};
      sel_d = b1[1:0];
      sec_d = '0;
      off_d = '0;
      last_d = 1'b0;
      gap_d = GW'(BYTE_GAP - 1);
      state_d = has_data ? S_DATA : S_STAT;
      status_d = has_data ? status_q : is_tur ? 8'h00 : 8'h02;
      sense_d = has_data || is_tur ? sense_q : 8'h05;
    end
    if (state_q == S_DATA) begin
      state_d = last_q ? S_STAT : S_DATA;
      status_d = last_q ? 8'h00 : status_q;
      sense_d = last_q && kind_q == K_RS ? 8'h00 : sense_q;
      gap_d = gap_q - GW'(1);
    end
    if (fire) begin
      cd_wr_d = 1'b1;
      cd_data_d = byte_s;
      gap_d = GW'(BYTE_GAP);
      last_d = last_byte;
      off_d = wrap ? 11'd0 : o_s + 11'd1;
      sec_d = wrap ? s_s + 9'd1 : s_s;
    end
    if (state_q == S_STAT && bus.STAT_GET) state_d = S_IDLE;
  end
  // state and registered outputs; reset aborts any transfer at once
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= S_IDLE;
      kind_q <= K_RS;
      lba_q <= '0;
      cnt_q <= '0;
      sec_q <= '0;
      off_q <= '0;
      sel_q <= '0;
      gap_q <= '0;
      last_q <= 1'b0;
      sense_q <= 8'h00;
      status_q <= 8'h00;
      cd_data_q <= 8'h00;
      cd_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      lba_q <= lba_d;
      cnt_q <= cnt_d;
      sec_q <= sec_d;
      off_q <= off_d;
      sel_q <= sel_d;
      gap_q <= gap_d;
      last_q <= last_d;
      sense_q <= sense_d;
      status_q <= status_d;
      cd_data_q <= cd_data_d;
      cd_wr_q <= cd_wr_d;
    end
  end
  assign bus.STATUS = status_q;
  assign bus.CD_DATA = cd_data_q;
  assign bus.CD_WR = cd_wr_q;
endmodule

// File: tb/tb_fake_cd_ctrl.sv
// tb_fake_cd_ctrl: table vectors, directed corner sequences and random commands against a queue-based model
module tb_fake_cd_ctrl;
  localparam int G = 2;
  localparam int SB = 2048;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] got_q[$];
  int gotc_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_status;
  logic [7:0] m_sense = 8'h00;
  fake_cd_ctrl_if bif();
  fake_cd_ctrl #(.BYTE_GAP(G), .SECTOR_BYTES(SB)) dut (.CLK(clk), .RES(rst), .bus(bif.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bif.CD_WR === 1'b1) begin
    got_q.push_back(bif.CD_DATA);
    gotc_q.push_back(cyc);
  end
  typedef struct {
    logic [7:0] op, b1, b2, b3, b4;
    int n;
    logic [7:0] st;
    logic [7:0] byte2;
  } vec_t;
  vec_t vt[8];
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask
  // reference: the byte stream and status a command should produce, derived straight from the command rules
  task automatic model(input logic [7:0] op, b1, b2, b3, b4);
    int lba, cnt;
    logic [7:0] toc[3][4];
    toc[0] = '{8'h01, 8'h01, 8'h00, 8'h00};
    toc[1] = '{8'h60, 8'h00, 8'h00, 8'h00};
    toc[2] = '{8'h00, 8'h02, 8'h00, 8'h04};
    exp_q.delete();
    if (op == 8'h00) exp_status = 8'h00;
    else if (op == 8'h03) begin
      for (int i = 0; i < 18; i++) exp_q.push_back(i == 0 ? 8'h70 : i == 2 ? m_sense : 8'h00);
      exp_status = 8'h00;
      m_sense = 8'h00;
    end else if (op == 8'h08) begin
      lba = int'({b1[4:0], b2, b3});
      cnt = b4 == 8'h00 ? 256 : int'(b4);
      for (int s = 0; s < cnt; s++)
        for (int k = 0; k < SB; k++) exp_q.push_back(8'(((lba + s) % (1 << 21)) ^ k));
      exp_status = 8'h00;
    end
`ifdef FAKE_CD_TOC_EN
    else if (op == 8'hDE && b1 <= 8'd2) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(toc[b1][i]);
      exp_status = 8'h00;
    end
`endif
    else begin
      exp_status = 8'h02;
      m_sense = 8'h05;
    end
  endtask
  task automatic stat_get();
    @(negedge clk);
    bif.STAT_GET = 1'b1;
    @(negedge clk);
    bif.STAT_GET = 1'b0;
  endtask
  // issue one command, collect its bytes and check them; inject>=0 pulses a stray COMM_SEND mid-transfer
  task automatic run_cmd(input logic [7:0] op, b1, b2, b3, b4, input int inject, input string nm);
    int c0, n, bad, badsp;
    model(op, b1, b2, b3, b4);
    n = exp_q.size();
    got_q.delete();
    gotc_q.delete();
    @(negedge clk);
    bif.COMMAND = {56'h0, b4, b3, b2, b1, op};
    bif.COMM_SEND = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bif.COMM_SEND = 1'b0;
    if (n == 0) begin
      check({nm, "/status_next_cycle"}, bif.STATUS, exp_status);
      repeat (3) @(negedge clk);
      check({nm, "/no_data"}, got_q.size(), 0);
    end else begin
      for (int i = 0; i < n * G + 20 && got_q.size() < n; i++) begin
        @(negedge clk);
        bif.COMM_SEND = i == inject;
        if (i == inject) bif.COMMAND = 96'h55;
      end
      bif.COMM_SEND = 1'b0;
      repeat (4) @(negedge clk);
      check({nm, "/count"}, got_q.size(), n);
      bad = 0;
      badsp = 0;
      for (int i = 0; i < got_q.size() && i < n; i++) begin
        if (got_q[i] !== exp_q[i]) begin
          if (bad == 0) $display("note %s first bad byte %0d: %02h vs %02h", nm, i, got_q[i], exp_q[i]);
          bad++;
        end
        if (gotc_q[i] != c0 + G * (i + 1)) badsp++;
      end
      check({nm, "/data_errors"}, bad, 0);
      check({nm, "/spacing_errors"}, badsp, 0);
      check({nm, "/data_hold"}, bif.CD_DATA, exp_q[n-1]);
      check({nm, "/status"}, bif.STATUS, exp_status);
    end
  endtask
  initial begin
    int n0;
    logic [7:0] op, b1;
    vt[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00};
    vt[1] = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h02, 8'h00};
    vt[2] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 18, 8'h00, 8'h05};
    vt[3] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 18, 8'h00, 8'h00};
`ifdef FAKE_CD_TOC_EN
    vt[4] = '{8'hDE, 8'h02, 8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h00};
    vt[5] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 18, 8'h00, 8'h00};
`else
    vt[4] = '{8'hDE, 8'h02, 8'h00, 8'h00, 8'h00, 0, 8'h02, 8'h00};
    vt[5] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 18, 8'h00, 8'h05};
`endif
    vt[6] = '{8'hDE, 8'h07, 8'h00, 8'h00, 8'h00, 0, 8'h02, 8'h00};
    vt[7] = '{8'h08, 8'h00, 8'h00, 8'h05, 8'h01, SB, 8'h00, 8'h07};
    rst = 1'b1;
    bif.COMM_SEND = 1'b0;
    bif.STAT_GET = 1'b0;
    bif.COMMAND = '0;
    repeat (3) @(negedge clk);
    check("reset/status", bif.STATUS, 8'h00);
    check("reset/cd_wr", bif.CD_WR, 1'b0);
    check("reset/cd_data", bif.CD_DATA, 8'h00);
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      run_cmd(vt[v].op, vt[v].b1, vt[v].b2, vt[v].b3, vt[v].b4, -1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d/table_count", v), got_q.size(), vt[v].n);
      check($sformatf("vec%0d/table_status", v), bif.STATUS, vt[v].st);
      if (vt[v].n > 2) check($sformatf("vec%0d/table_byte2", v), got_q[2], vt[v].byte2);
      stat_get();
    end
    check("read5/byte0", got_q[0], 8'h05);
    check("read5/byte1", got_q[1], 8'h04);
    check("read5/byte255", got_q[255], 8'hFA);
    run_cmd(8'h08, 8'h01, 8'h23, 8'h45, 8'h01, 50, "mid_send");
    stat_get();
    run_cmd(8'h08, 8'h1F, 8'hFF, 8'hFF, 8'h02, -1, "lba_wrap");
    stat_get();
    run_cmd(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, -1, "pre_tur");
    stat_get();
    run_cmd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, "tur_hold");
    @(negedge clk);
    bif.COMMAND = 96'h55;
    bif.COMM_SEND = 1'b1;
    @(negedge clk);
    bif.COMM_SEND = 1'b0;
    repeat (2) @(negedge clk);
    check("stat/send_ignored", bif.STATUS, 8'h00);
    @(negedge clk);
    bif.COMM_SEND = 1'b1;
    bif.STAT_GET = 1'b1;
    @(negedge clk);
    bif.COMM_SEND = 1'b0;
    bif.STAT_GET = 1'b0;
    repeat (2) @(negedge clk);
    check("stat/send_dropped", bif.STATUS, 8'h00);
    run_cmd(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, -1, "sense_after_stat");
    stat_get();
    run_cmd(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, -1, "pre_rst");
    stat_get();
    got_q.delete();
    gotc_q.delete();
    @(negedge clk);
    bif.COMMAND = {56'h0, 8'h01, 8'h09, 8'h00, 8'h00, 8'h08};
    bif.COMM_SEND = 1'b1;
    @(negedge clk);
    bif.COMM_SEND = 1'b0;
    for (int i = 0; i < 400 && got_q.size() < 100; i++) @(negedge clk);
    check("rst/bytes_before", got_q.size(), 100);
    rst = 1'b1;
    #1;
    check("rst/cd_wr", bif.CD_WR, 1'b0);
    check("rst/status", bif.STATUS, 8'h00);
    check("rst/cd_data", bif.CD_DATA, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    m_sense = 8'h00;
    n0 = got_q.size();
    repeat (30) @(negedge clk);
    check("rst/no_more_wr", got_q.size(), n0);
    run_cmd(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, -1, "post_rst_sense");
    stat_get();
    run_cmd(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, -1, "post_rst_accept");
    stat_get();
    for (int r = 0; r < 8; r++) begin
      b1 = 8'($urandom);
      case ($urandom_range(0, 4))
        0: op = 8'h00;
        1: op = 8'h03;
        2: op = 8'h08;
        3: begin op = 8'hDE; b1 = 8'($urandom_range(0, 3)); end
        default: begin
          op = 8'($urandom);
          if (op == 8'h00 || op == 8'h03 || op == 8'h08 || op == 8'hDE) op = 8'hA5;
        end
      endcase
      run_cmd(op, b1, 8'($urandom), 8'($urandom), 8'h01, -1, $sformatf("rand%0d_op%02h", r, op));
      stat_get();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fake_cd_ctrl.md
# fake_cd_ctrl

Behavioural stand-in for a CD-ROM drive mechanism, sitting behind the SCSI bus bridge on the HuC6272 side of the machine. It accepts 12-byte SCSI command blocks from the bridge and executes a small command subset. It streams synthetic response data back to the bridge one byte per write strobe and presents a status byte. The bridge's status handshake then returns the block to idle.

## Interface
Parameters:
- BYTE_GAP, 8: clock cycles from one CD_WR pulse to the next, and from command accept to the first CD_WR; legal range ≥1.
- SECTOR_BYTES, 2048: bytes per sector returned by READ(6).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RES  in  1  reset, asynchronous and active-high.
- COMM_SEND  in  1  one-cycle pulse; COMMAND is valid in that cycle.
- COMMAND  in  96  command block; byte n = COMMAND[8n+7:8n]; byte 0 is the opcode.
- STAT_GET  in  1  one-cycle pulse; the bridge has consumed STATUS.
- STATUS  out  8  status of the last completed command: 0x00 GOOD, 0x02 CHECK CONDITION.
- CD_DATA  out  8  data byte; valid while CD_WR=1.
- CD_WR  out  1  one-cycle data strobe.

## Operation
- States: IDLE, DATA, STAT. After reset: IDLE, STATUS=0x00, CD_DATA=0x00, CD_WR=0, sense key=0x00.
- IDLE: on COMM_SEND, latch COMMAND, decode byte 0, enter DATA. If the command has zero data bytes, enter STAT directly.
- COMM_SEND in DATA or STAT is ignored; the latched command is unchanged.
- 0x00 TEST UNIT READY: no data; STATUS=0x00.
- 0x03 REQUEST SENSE: 18 bytes; byte0=0x70, byte2=current sense key, all other bytes 0x00; STATUS=0x00; sense key then clears to 0x00.
- 0x08 READ(6):
  - LBA = {byte1[4:0], byte2, byte3}; count = byte4, where 0 means 256.
  - Sends count×SECTOR_BYTES bytes. Byte k of sector s = (LBA+s)[7:0] XOR k[7:0].
  - STATUS=0x00.
- 0xDE READ TOC (FAKE_CD_TOC_EN only), selected by byte1:
  - 0: 4 bytes 0x01,0x01,0x00,0x00.
  - 1: 4 bytes 0x60,0x00,0x00,0x00.
  - 2: 4 bytes 0x00,0x02,0x00,0x04.
  - Any other byte1 value is treated as an unsupported command.
- Any other opcode: no data; STATUS=0x02; sense key=0x05.
- DATA → STAT in the cycle after the final CD_WR. STATUS is updated on entry to STAT and holds until the next command completes.
- STAT: on STAT_GET, go to IDLE. STAT_GET in any other state is ignored.
- Byte offset counter is 11 bits wrapping at SECTOR_BYTES; the sector counter is 9 bits; LBA+s is 21-bit, modulo 2^21.

## Timing
- Command accept: the state changes in the cycle after COMM_SEND.
- First CD_WR occurs BYTE_GAP cycles after the COMM_SEND cycle; later pulses follow every BYTE_GAP cycles; CD_WR is never held high two cycles in a row.
- CD_DATA changes only in CD_WR cycles and holds the last byte otherwise.
- Zero-data command: STAT is reached one cycle after COMM_SEND.
- RES asserted at any time aborts a transfer immediately: no further CD_WR, all outputs return to their reset values.
- COMM_SEND and STAT_GET arriving in the same cycle while in STAT: go to IDLE and drop the command.

## Configuration
- FAKE_CD_TOC_EN defined: opcode 0xDE is decoded as above.
- Without FAKE_CD_TOC_EN: 0xDE takes the unsupported-command path (STATUS=0x02, sense key 0x05) and no TOC logic is built.

## Test plan
- Reset, then COMMAND byte0=0x00 with COMM_SEND → no CD_WR, STATUS=0x00, STAT one cycle later; STAT_GET → IDLE.
- READ(6) with LBA=5, count=1, SECTOR_BYTES=2048 → exactly 2048 CD_WR pulses spaced BYTE_GAP apart; byte0=0x05, byte1=0x04, byte255=0xFA; then STATUS=0x00.
- Opcode 0x55 → STATUS=0x02; then REQUEST SENSE → 18 bytes with byte0=0x70, byte2=0x05, STATUS=0x00; a second REQUEST SENSE returns byte2=0x00.
- READ TOC with byte1=2 and FAKE_CD_TOC_EN defined → bytes 0x00,0x02,0x00,0x04; without the macro → STATUS=0x02, no data.
- COMM_SEND pulsed mid-READ → ignored; byte count and pattern unchanged.
- RES pulsed after 100 bytes of a READ → CD_WR stops, STATUS=0x00, next COMM_SEND accepted from IDLE.
